bpu_ras_ckpt: RTL and testbench
===============================

// Module: bpu_ras_ckpt
// PURPOSE
//  Parametrised return-address stack for the BPU. Sits beside the BHT in pre_IF.
//  Pushes the return target on a predicted CALL and supplies the target on a predicted RET.
//  Each entry carries a recursion counter, so repeated pushes of the same address reuse one slot.
//  Exports a per-prediction checkpoint and restores from it on a verify-stage mispredict (CORRECTION).
// PARAMETERS
//  DEPTH   8   number of stack entries; power of 2, >=2
//  CNT_W   2   recursion counter width; an entry holds up to 2**CNT_W pushes
//  ADDR_W  32  return-address width (virt_t)
// PORTS
//  clk          in   1                  clock, rising edge
//  reset        in   1                  asynchronous, active-high reset
//  push_i       in   1                  predicted CALL this cycle (br_type == B_IS_CALL)
//  push_addr_i  in   ADDR_W             return address to push (call pc + 8)
//  pop_i        in   1                  predicted RET this cycle (br_type == B_IS_RET)
//  top_valid_o  out  1                  stack non-empty; top_addr_o is meaningful
//  top_addr_o   out  ADDR_W             predicted return target
//  ckpt_o       out  $bits(ras_ckpt_t)  snapshot of the current state; travels with the branch
//  recover_i    in   1                  mispredict: restore the state held in recover_ckpt_i
//  recover_ckpt_i in $bits(ras_ckpt_t)  checkpoint captured when the mispredicted branch was predicted
// BEHAVIOUR
//  State
//   - Storage: entry[DEPTH] of {valid, addr, cnt}.
//   - tos: $clog2(DEPTH) bits, wraps modulo DEPTH.
//   - occ: 0..DEPTH, $clog2(DEPTH)+1 bits.
//  Reset (async): tos=0, occ=0, all valid=0, addr=0, cnt=0.
//   - Outputs at reset: top_valid_o=0, top_addr_o=0, ckpt_o=all-zero.
//  Outputs: combinational from registers, no bypass. An update is visible the cycle after it.
//   - top_valid_o = (occ != 0).
//   - top_addr_o = entry[tos].addr when occ != 0, else 0.
//   - ckpt_o = {tos, occ, entry[tos].addr, entry[tos].cnt}.
//  Priority each cycle: recover_i > (push_i & pop_i) > push_i > pop_i.
//  recover_i
//   - Load tos and occ from the checkpoint.
//   - Rewrite entry[ckpt.tos] = {occ!=0, ckpt.addr, ckpt.cnt}.
//   - Ignore push and pop in the same cycle.
//   - Entries other than ckpt.tos are left unchanged.
//  push only
//   - Same address, counter not full (occ != 0, addr == push_addr_i, cnt != 2**CNT_W-1):
//     cnt++, no pointer move.
//   - Otherwise: tos++ (wrap), entry[tos+1] = {1, push_addr_i, 0}, occ = min(occ+1, DEPTH).
//   - When occ == DEPTH, the oldest entry is silently overwritten.
//  pop only
//   - occ == 0: no-op; tos and occ stay 0, no underflow.
//   - cnt > 0: cnt--.
//   - cnt == 0: valid=0, tos-- (wrap), occ--.
//  push & pop together (RET that also CALLs)
//   - occ > 0: entry[tos] = {1, push_addr_i, 0}; tos and occ unchanged.
//   - occ == 0: behaves as push only.
//  No handshake or stall: every request is accepted in the cycle it is asserted. Single-cycle latency.
//  reset asserted mid-operation: state clears immediately; requests in that cycle are dropped.
// STRUCTURE
//  Shared package / cpu_defs.svh:
//   - extend ras_t with cnt.
//   - add typedef ras_ckpt_t {tos, occ, addr, cnt}.
//   - add `RAS_DEPTH 8 and `RAS_CNT_W 2.
//   - verify_result_t gains a ras_ckpt_t field.
//  Single flat module; no sub-module.
//  Storage uses flops (DEPTH is small); tos/occ update logic lives in one always_ff.
// TESTING
//  1. Reset, then pop -> top_valid_o=0, occ stays 0, no X on outputs.
//  2. Push 0x80000100, then push 0x80000200 -> top=0x80000200.
//     Then pop -> top=0x80000100. Then pop -> top_valid_o=0.
//  3. Push 0x8000_0400 five times (CNT_W=2) -> cnt saturates at 3; the 5th push opens a new slot (occ=2).
//     Then five pops -> empty.
//  4. DEPTH=8: push A0..A8 (9 distinct) -> occ=8 and top=A8.
//     Then eight pops return A8..A1 -> empty (A0 lost).
//  5. Capture ckpt_o (top=A1, occ=2); push A2, then pop twice.
//     Then recover_i with that ckpt -> top=A1, occ=2, next pop returns A0.
//  6. Same cycle: recover_i plus push_i and pop_i -> only recover applied.
//     Separately, push and pop with occ=1 top=A0, push_addr=B -> top=B, occ=1.

Source files
------------

// File: rtl/bpu_ras_ckpt_pkg.sv
// Shared return-address-stack types and default sizing for the BPU.
// Checkpoint layout, MSB first: {tos, occ, addr, cnt}.
package bpu_ras_ckpt_pkg;

  localparam int RAS_DEPTH  = 8;
  localparam int RAS_CNT_W  = 2;
  localparam int RAS_ADDR_W = 32;
  localparam int RAS_TOS_W  = $clog2(RAS_DEPTH);
  localparam int RAS_OCC_W  = RAS_TOS_W + 1;

  typedef struct packed {
    logic                  valid;
    logic [RAS_ADDR_W-1:0] addr;
    logic [RAS_CNT_W-1:0]  cnt;
  } ras_t;

  typedef struct packed {
    logic [RAS_TOS_W-1:0]  tos;
    logic [RAS_OCC_W-1:0]  occ;
    logic [RAS_ADDR_W-1:0] addr;
    logic [RAS_CNT_W-1:0]  cnt;
  } ras_ckpt_t;

endpackage

// File: rtl/bpu_ras_ckpt.sv
// Return-address stack with per-entry recursion counters and checkpoint/restore
// for verify-stage mispredict recovery.
module bpu_ras_ckpt
  import bpu_ras_ckpt_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int CNT_W  = RAS_CNT_W,
  parameter int ADDR_W = RAS_ADDR_W
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          push_i,
  input  logic [ADDR_W-1:0]                             push_addr_i,
  input  logic                                          pop_i,
  output logic                                          top_valid_o,
  output logic [ADDR_W-1:0]                             top_addr_o,
  output logic [2*$clog2(DEPTH)+1+ADDR_W+CNT_W-1:0]     ckpt_o,
  input  logic                                          recover_i,
  input  logic [2*$clog2(DEPTH)+1+ADDR_W+CNT_W-1:0]     recover_ckpt_i
);

  localparam int TOS_W = $clog2(DEPTH);
  localparam int OCC_W = TOS_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef struct packed {
    logic [TOS_W-1:0]  tos;
    logic [OCC_W-1:0]  occ;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
  } ckpt_t;

  logic              valid [DEPTH];
  logic [ADDR_W-1:0] addr  [DEPTH];
  logic [CNT_W-1:0]  cnt   [DEPTH];
  logic [TOS_W-1:0]  tos;
  logic [OCC_W-1:0]  occ;

  ckpt_t            rc;
  logic             nonempty;
  logic             same_hit;
  logic [TOS_W-1:0] tos_inc;
  logic [TOS_W-1:0] tos_dec;

  assign rc       = ckpt_t'(recover_ckpt_i);
  assign nonempty = (occ != '0);
  assign tos_inc  = tos + 1'b1;
  assign tos_dec  = tos - 1'b1;
  // A repeated call to the live top address folds into its counter until it saturates.
  assign same_hit = nonempty && valid[tos] && (addr[tos] == push_addr_i) && (cnt[tos] != CNT_MAX);

  assign top_valid_o = nonempty;
  assign top_addr_o  = nonempty ? addr[tos] : '0;
  assign ckpt_o      = {tos, occ, addr[tos], cnt[tos]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid[i] <= 1'b0;
        addr[i]  <= '0;
        cnt[i]   <= '0;
      end
    end else if (recover_i) begin
      tos            <= rc.tos;
      occ            <= rc.occ;
      valid[rc.tos]  <= (rc.occ != '0);
      addr[rc.tos]   <= rc.addr;
      cnt[rc.tos]    <= rc.cnt;
    end else if (push_i && pop_i && nonempty) begin
      // RET+CALL: the returning frame is replaced in place.
      valid[tos] <= 1'b1;
      addr[tos]  <= push_addr_i;
      cnt[tos]   <= '0;
    end else if (push_i) begin
      if (same_hit) begin
        cnt[tos] <= cnt[tos] + 1'b1;
      end else begin
        tos            <= tos_inc;
        valid[tos_inc] <= 1'b1;
        addr[tos_inc]  <= push_addr_i;
        cnt[tos_inc]   <= '0;
        if (occ != OCC_FULL) occ <= occ + 1'b1;
      end
    end else if (pop_i && nonempty) begin
      if (cnt[tos] != '0) begin
        cnt[tos] <= cnt[tos] - 1'b1;
      end else begin
        valid[tos] <= 1'b0;
        tos        <= tos_dec;
        occ        <= occ - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bpu_ras_ckpt.sv
// Directed bench for bpu_ras_ckpt: push/pop, recursion counters, overflow wrap,
// checkpoint restore and same-cycle priority.
module tb_bpu_ras_ckpt;
  import bpu_ras_ckpt_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  push_i;
  logic [RAS_ADDR_W-1:0] push_addr_i;
  logic                  pop_i;
  logic                  top_valid_o;
  logic [RAS_ADDR_W-1:0] top_addr_o;
  ras_ckpt_t             ckpt_o;
  logic                  recover_i;
  ras_ckpt_t             recover_ckpt_i;

  int checks = 0;
  int errors = 0;

  bpu_ras_ckpt dut (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push_i),
    .push_addr_i   (push_addr_i),
    .pop_i         (pop_i),
    .top_valid_o   (top_valid_o),
    .top_addr_o    (top_addr_o),
    .ckpt_o        (ckpt_o),
    .recover_i     (recover_i),
    .recover_ckpt_i(recover_ckpt_i)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
    push_i    = 1'b0;
    pop_i     = 1'b0;
    recover_i = 1'b0;
  endtask

  task automatic do_push(input logic [RAS_ADDR_W-1:0] a);
    push_i = 1'b1; push_addr_i = a; cycle();
  endtask

  task automatic do_pop();
    pop_i = 1'b1; cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; push_i = 1'b0; pop_i = 1'b0; recover_i = 1'b0;
    push_addr_i = '0; recover_ckpt_i = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (top_valid_o !== 1'b0 || top_addr_o !== '0 || ckpt_o !== '0) begin
      errors++; $display("FAIL reset_state: valid=%b addr=%h ckpt=%h, want 0/0/0", top_valid_o, top_addr_o, ckpt_o);
    end
    do_pop();
    checks++;
    if (top_valid_o !== 1'b0 || ckpt_o.occ !== 4'd0 || ckpt_o.tos !== 3'd0) begin
      errors++; $display("FAIL pop_empty: valid=%b occ=%0d tos=%0d, want 0/0/0", top_valid_o, ckpt_o.occ, ckpt_o.tos);
    end
    checks++;
    if ($isunknown({top_valid_o, top_addr_o, ckpt_o})) begin
      errors++; $display("FAIL no_x: outputs %b %h %h contain X, want known", top_valid_o, top_addr_o, ckpt_o);
    end
  endtask

  task automatic test_push_pop();
    do_push(32'h8000_0100);
    do_push(32'h8000_0200);
    checks++;
    if (top_valid_o !== 1'b1 || top_addr_o !== 32'h8000_0200 || ckpt_o.occ !== 4'd2) begin
      errors++; $display("FAIL push2: valid=%b top=%h occ=%0d, want 1/80000200/2", top_valid_o, top_addr_o, ckpt_o.occ);
    end
    do_pop();
    checks++;
    if (top_addr_o !== 32'h8000_0100 || ckpt_o.occ !== 4'd1) begin
      errors++; $display("FAIL pop1: top=%h occ=%0d, want 80000100/1", top_addr_o, ckpt_o.occ);
    end
    do_pop();
    checks++;
    if (top_valid_o !== 1'b0 || top_addr_o !== '0) begin
      errors++; $display("FAIL pop2_empty: valid=%b top=%h, want 0/0", top_valid_o, top_addr_o);
    end
  endtask

  task automatic test_recursion();
    for (int i = 0; i < 4; i++) do_push(32'h8000_0400);
    checks++;
    if (ckpt_o.occ !== 4'd1 || ckpt_o.cnt !== 2'd3 || top_addr_o !== 32'h8000_0400) begin
      errors++; $display("FAIL rec_sat: occ=%0d cnt=%0d top=%h, want 1/3/80000400", ckpt_o.occ, ckpt_o.cnt, top_addr_o);
    end
    do_push(32'h8000_0400);
    checks++;
    if (ckpt_o.occ !== 4'd2 || ckpt_o.cnt !== 2'd0) begin
      errors++; $display("FAIL rec_newslot: occ=%0d cnt=%0d, want 2/0", ckpt_o.occ, ckpt_o.cnt);
    end
    do_pop();
    checks++;
    if (ckpt_o.occ !== 4'd1 || ckpt_o.cnt !== 2'd3) begin
      errors++; $display("FAIL rec_pop1: occ=%0d cnt=%0d, want 1/3", ckpt_o.occ, ckpt_o.cnt);
    end
    for (int i = 0; i < 3; i++) do_pop();
    checks++;
    if (ckpt_o.occ !== 4'd1 || ckpt_o.cnt !== 2'd0 || top_valid_o !== 1'b1) begin
      errors++; $display("FAIL rec_pop4: occ=%0d cnt=%0d valid=%b, want 1/0/1", ckpt_o.occ, ckpt_o.cnt, top_valid_o);
    end
    do_pop();
    checks++;
    if (top_valid_o !== 1'b0 || ckpt_o.occ !== 4'd0) begin
      errors++; $display("FAIL rec_empty: valid=%b occ=%0d, want 0/0", top_valid_o, ckpt_o.occ);
    end
  endtask

  task automatic test_overflow();
    logic [RAS_ADDR_W-1:0] a;
    for (int i = 0; i < 9; i++) do_push(32'h9000_0000 + 32'(i * 16));
    checks++;
    if (ckpt_o.occ !== 4'd8 || top_addr_o !== 32'h9000_0080) begin
      errors++; $display("FAIL ovf_full: occ=%0d top=%h, want 8/90000080", ckpt_o.occ, top_addr_o);
    end
    for (int k = 0; k < 8; k++) begin
      a = 32'h9000_0000 + 32'((8 - k) * 16);
      checks++;
      if (top_valid_o !== 1'b1 || top_addr_o !== a) begin
        errors++; $display("FAIL ovf_pop%0d: valid=%b top=%h, want 1/%h", k, top_valid_o, top_addr_o, a);
      end
      do_pop();
    end
    checks++;
    if (top_valid_o !== 1'b0 || ckpt_o.occ !== 4'd0) begin
      errors++; $display("FAIL ovf_empty: valid=%b occ=%0d, want 0/0", top_valid_o, ckpt_o.occ);
    end
  endtask

  task automatic test_recover();
    ras_ckpt_t ck;
    do_push(32'hA000_0000);
    do_push(32'hA000_0001);
    ck = ckpt_o;
    checks++;
    if (ck.occ !== 4'd2 || ck.addr !== 32'hA000_0001) begin
      errors++; $display("FAIL rcv_capture: occ=%0d addr=%h, want 2/a0000001", ck.occ, ck.addr);
    end
    do_push(32'hA000_0002);
    do_pop();
    do_pop();
    checks++;
    if (top_addr_o !== 32'hA000_0000 || ckpt_o.occ !== 4'd1) begin
      errors++; $display("FAIL rcv_before: top=%h occ=%0d, want a0000000/1", top_addr_o, ckpt_o.occ);
    end
    recover_i = 1'b1; recover_ckpt_i = ck; cycle();
    checks++;
    if (top_valid_o !== 1'b1 || top_addr_o !== 32'hA000_0001 || ckpt_o.occ !== 4'd2 || ckpt_o.tos !== ck.tos) begin
      errors++; $display("FAIL rcv_restore: valid=%b top=%h occ=%0d tos=%0d, want 1/a0000001/2/%0d",
                         top_valid_o, top_addr_o, ckpt_o.occ, ckpt_o.tos, ck.tos);
    end
    do_pop();
    checks++;
    if (top_addr_o !== 32'hA000_0000 || ckpt_o.occ !== 4'd1) begin
      errors++; $display("FAIL rcv_pop: top=%h occ=%0d, want a0000000/1", top_addr_o, ckpt_o.occ);
    end
    do_pop();
  endtask

  task automatic test_same_cycle();
    ras_ckpt_t ck;
    do_push(32'hA000_0000);
    ck = ckpt_o;
    do_push(32'hA000_0001);
    recover_i = 1'b1; recover_ckpt_i = ck;
    push_i = 1'b1; pop_i = 1'b1; push_addr_i = 32'hB000_0000;
    cycle();
    checks++;
    if (top_addr_o !== 32'hA000_0000 || ckpt_o.occ !== 4'd1 || ckpt_o.tos !== ck.tos) begin
      errors++; $display("FAIL prio_recover: top=%h occ=%0d tos=%0d, want a0000000/1/%0d",
                         top_addr_o, ckpt_o.occ, ckpt_o.tos, ck.tos);
    end
    push_i = 1'b1; pop_i = 1'b1; push_addr_i = 32'hB000_0000;
    cycle();
    checks++;
    if (top_addr_o !== 32'hB000_0000 || ckpt_o.occ !== 4'd1 || ckpt_o.tos !== ck.tos || ckpt_o.cnt !== 2'd0) begin
      errors++; $display("FAIL pushpop_replace: top=%h occ=%0d tos=%0d cnt=%0d, want b0000000/1/%0d/0",
                         top_addr_o, ckpt_o.occ, ckpt_o.tos, ckpt_o.cnt, ck.tos);
    end
    do_pop();
    push_i = 1'b1; pop_i = 1'b1; push_addr_i = 32'hC000_0000;
    cycle();
    checks++;
    if (top_valid_o !== 1'b1 || top_addr_o !== 32'hC000_0000 || ckpt_o.occ !== 4'd1) begin
      errors++; $display("FAIL pushpop_empty: valid=%b top=%h occ=%0d, want 1/c0000000/1", top_valid_o, top_addr_o, ckpt_o.occ);
    end
  endtask

  task automatic test_async_reset();
    do_push(32'hD000_0000);
    @(negedge clk);
    push_i = 1'b1; push_addr_i = 32'hE000_0000;
    reset = 1'b1;
    #1;
    checks++;
    if (top_valid_o !== 1'b0 || ckpt_o !== '0) begin
      errors++; $display("FAIL async_reset: valid=%b ckpt=%h, want 0/0", top_valid_o, ckpt_o);
    end
    @(posedge clk);
    #1;
    push_i = 1'b0;
    reset  = 1'b0;
    checks++;
    if (top_valid_o !== 1'b0 || ckpt_o !== '0) begin
      errors++; $display("FAIL reset_drops_push: valid=%b ckpt=%h, want 0/0", top_valid_o, ckpt_o);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_recursion();
    test_overflow();
    test_recover();
    test_same_cycle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
